// File: rtl/mux_nto1_stream.sv
// N-channel stream multiplexer with a registered output word, valid/ready on
// every channel, and either a fixed select or round-robin channel choice.
module mux_nto1_stream #(
    parameter int N_CH  = 16,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N_CH),
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic [N_CH-1:0]     in_valid,
    output logic [N_CH-1:0]     in_ready,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SEL_W-1:0]    out_ch,
    output logic [CNT_W-1:0]    xfer_cnt
);

    logic [W-1:0]     out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic [CNT_W-1:0] xfer_cnt_q,  xfer_cnt_d;
    logic [SEL_W-1:0] last_q,      last_d;

    logic             load_s;
    logic             grant_vld_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic             accept_s;

    assign load_s   = !out_valid_q || out_ready;
    assign accept_s = load_s && grant_vld_s;

    // Grant selection: fixed channel, or first valid channel after last_q (wrapping).
    always_comb begin
        logic [SEL_W:0] cand;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand        = '0;
        if (mode) begin
            for (int i = 1; i <= N_CH; i++) begin
                // last_q never exceeds N_CH-1, so one subtraction brings cand back in range.
                cand = {1'b0, last_q} + (SEL_W+1)'(i);
                if (cand >= (SEL_W+1)'(N_CH)) begin
                    cand = cand - (SEL_W+1)'(N_CH);
                end else begin
                    cand = cand;
                end
                if (!grant_vld_s && in_valid[cand[SEL_W-1:0]]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = cand[SEL_W-1:0];
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            if (({1'b0, sel} < (SEL_W+1)'(N_CH)) && in_valid[sel]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = sel;
            end else begin
                grant_vld_s = 1'b0;
            end
        end
    end

    // Ready is asserted only toward the granted channel, and only when the output can load.
    always_comb begin
        in_ready = '0;
        if (accept_s) begin
            in_ready[grant_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Next-state for the output register, round-robin pointer and handshake counter.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (out_valid_q && out_ready) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end
        if (accept_s) begin
            out_data_d  = in_data[grant_idx_s*W +: W];
            out_ch_d    = grant_idx_s;
            out_valid_d = 1'b1;
            if (mode) begin
                last_d = grant_idx_s;
            end else begin
                last_d = last_q;
            end
        end else if (load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; last_q resets to N_CH-1 so the first round-robin search starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            xfer_cnt_q  <= '0;
            last_q      <= SEL_W'(N_CH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            xfer_cnt_q  <= xfer_cnt_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Self-checking bench for mux_nto1_stream: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_mux_nto1_stream;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int SW = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_ch;
    logic [CW-1:0]   xfer_cnt;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    mux_nto1_stream #(.N_CH(N), .W(W), .SEL_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    // Reference choice: fixed sel if valid; RR = lowest valid channel above last, else lowest valid.
    function automatic int pick(input logic m, input int s, input logic [N-1:0] v, input int last);
        int above;
        int lowest;
        above  = -1;
        lowest = -1;
        if (!m) return (s < N && v[s]) ? s : -1;
        for (int c = 0; c < N; c++) begin
            if (v[c]) begin
                if (lowest < 0) lowest = c;
                if (c > last && above < 0) above = c;
            end
        end
        return (above >= 0) ? above : lowest;
    endfunction

    logic          m_valid;
    logic [W-1:0]  m_data;
    int            m_ch;
    int            m_cnt;
    int            m_last;
    int            m_g;
    logic          m_load;

    always_comb m_load = !m_valid || out_ready;
    always_comb m_g    = pick(mode, int'(sel), in_valid, m_last);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= 0;
            m_cnt   <= 0;
            m_last  <= N - 1;
        end else begin
            if (m_valid && out_ready) m_cnt <= (m_cnt + 1) % (1 << CW);
            if (m_load) begin
                m_valid <= (m_g >= 0);
                if (m_g >= 0) begin
                    m_data <= in_data[m_g*W +: W];
                    m_ch   <= m_g;
                    if (mode) m_last <= m_g;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [N-1:0] exp_rdy;
            exp_rdy = '0;
            if (m_load && m_g >= 0) exp_rdy[m_g] = 1'b1;
            chk("model_out_valid", 64'(out_valid), 64'(m_valid));
            chk("model_xfer_cnt",  64'(xfer_cnt),  64'(m_cnt));
            chk("model_in_ready",  64'(in_ready),  64'(exp_rdy));
            if (m_valid) begin
                chk("model_out_data", 64'(out_data), 64'(m_data));
                chk("model_out_ch",   64'(out_ch),   64'(m_ch));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
    endtask

    task automatic ramp_data();
        for (int c = 0; c < N; c++) in_data[c*W +: W] = 16'h3f00 + 16'(c);
    endtask

    initial begin
        int steps[4];
        steps = '{0, 1, 6, 12};
        rst_n = 1'b0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        in_valid = '0; in_data = '0;
        cyc();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data",  64'(out_data),  64'd0);
        chk("reset_out_ch",    64'(out_ch),    64'd0);
        chk("reset_xfer_cnt",  64'(xfer_cnt),  64'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Fixed select stepping
        ramp_data(); in_valid = 16'hffff; out_ready = 1'b1; mode = 1'b0;
        foreach (steps[k]) begin
            sel = SW'(steps[k]);
            #1;
            chk("fixed_in_ready", 64'(in_ready), 64'(16'h1 << steps[k]));
            cyc();
            chk("fixed_out_data", 64'(out_data), 64'(16'h3f00 + steps[k]));
            chk("fixed_out_ch",   64'(out_ch),   64'(steps[k]));
        end

        // Round-robin fairness from fresh reset
        do_reset();
        mode = 1'b1; in_valid = 16'h8421; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rr_out_ch", 64'(out_ch), 64'((i % 4) * 5));
        end
        in_valid = '0;
        cyc();
        chk("rr_xfer_cnt", 64'(xfer_cnt), 64'd8);
        chk("rr_drained",  64'(out_valid), 64'd0);

        // Backpressure
        ramp_data(); in_valid = 16'hffff;
        cyc();
        chk("bp_first_ch", 64'(out_ch), 64'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < N; c++) in_data[c*W +: W] = 16'($urandom);
            in_valid = 16'($urandom) | 16'h0001;
            mode = 1'($urandom);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            cyc();
            chk("bp_out_data", 64'(out_data), 64'h3f00);
            chk("bp_out_ch",   64'(out_ch),   64'd0);
            chk("bp_xfer_cnt", 64'(xfer_cnt), 64'd8);
        end
        ramp_data(); in_valid = 16'hffff; mode = 1'b1; out_ready = 1'b1;
        cyc();
        chk("bp_release_cnt",  64'(xfer_cnt),  64'd9);
        chk("bp_release_ch",   64'(out_ch),    64'd1);
        chk("bp_release_data", 64'(out_data),  64'h3f01);
        chk("bp_release_vld",  64'(out_valid), 64'd1);

        // Fixed select on an invalid channel
        mode = 1'b0; sel = 4'd3; in_valid = 16'hfff7;
        #1;
        chk("fix_nogrant_rdy", 64'(in_ready), 64'd0);
        cyc();
        chk("fix_nogrant_vld", 64'(out_valid), 64'd0);
        chk("fix_nogrant_cnt", 64'(xfer_cnt),  64'd10);

        // RR wrap with a single channel valid
        mode = 1'b1; in_valid = 16'h8000;
        cyc();
        chk("rr_wrap_ch1", 64'(out_ch), 64'd15);
        cyc();
        chk("rr_wrap_ch2", 64'(out_ch), 64'd15);
        chk("rr_wrap_vld", 64'(out_valid), 64'd1);
        chk("rr_wrap_cnt", 64'(xfer_cnt), 64'd11);

        // Counter wrap with back-to-back transfers
        do_reset();
        in_valid = 16'hffff; mode = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            cyc();
            if (i == 16) chk("wrap_cnt_15", 64'(xfer_cnt), 64'd15);
            if (i == 17) chk("wrap_cnt_0",  64'(xfer_cnt), 64'd0);
            if (i == 18) chk("wrap_cnt_1",  64'(xfer_cnt), 64'd1);
        end

        // Asynchronous reset during a stall
        out_ready = 1'b0;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 64'(out_valid), 64'd0);
        chk("areset_xfer_cnt",  64'(xfer_cnt),  64'd0);
        chk("areset_out_data",  64'(out_data),  64'd0);
        #2;
        rst_n = 1'b1;
        mode = 1'b1; in_valid = 16'h0050; out_ready = 1'b1;
        cyc();
        chk("areset_first_rr", 64'(out_ch), 64'd4);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++) in_data[c*W +: W] = 16'($urandom);
            in_valid  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
            mode      = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
            sel       = SW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (i == 300) do_reset();
            cyc();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_nto1_stream.md
Name: mux_nto1_stream

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output stage and valid/ready flow control on every channel.
- Two selection modes:
  - fixed select, where the sel port picks the channel;
  - round-robin across all channels presenting valid.
- Sits between several producer streams and a single consumer. It is the clocked, multi-mode successor to the team's combinational 16:1 mux.

Parameters:
- N_CH, 16, number of input channels (2..64).
- W, 8, data width per channel.
- SEL_W, $clog2(N_CH), width of sel and out_ch.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N_CH*W  channel c occupies bits [c*W +: W]
- in_valid  input  N_CH  per-channel valid
- in_ready  output  N_CH  per-channel ready (combinational, one-hot or zero)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index used in fixed mode
- out_data  output  W  registered selected data
- out_valid  output  1  output holds a word
- out_ready  input  1  consumer accepts
- out_ch  output  SEL_W  channel index the current out_data came from
- xfer_cnt  output  CNT_W  count of completed output handshakes

Behaviour:
- Reset (async assert, sync release):
  - out_data=0, out_valid=0, out_ch=0, xfer_cnt=0.
  - RR pointer last=N_CH-1, so the first RR search starts at channel 0.
- load = !out_valid || out_ready. The output register may take a new word only when load=1.
- Grant g is combinational:
  - Fixed mode: g=sel if in_valid[sel]; otherwise no grant. sel >= N_CH means no grant.
  - RR mode: g is the first c with in_valid[c]=1, searching last+1, last+2, … wrapping modulo N_CH. No grant if in_valid==0.
- in_ready[g] = load && grant_exists. All other in_ready bits are 0. in_ready never depends on in_valid of a non-granted channel.
- Accept (in_valid[g] && in_ready[g]) at edge k:
  - out_data=in_data[g], out_ch=g, out_valid=1 after edge k (1-cycle latency).
  - In RR mode, last=g.
  - In fixed mode, last is unchanged.
- out_ready=1 with no accept in the same cycle: out_valid drops to 0.
- Simultaneous output handshake and new accept: the register reloads, out_valid stays 1 (full throughput, one word per cycle).
- Stall (out_valid=1, out_ready=0):
  - out_data and out_ch hold stable.
  - All in_ready=0.
- xfer_cnt increments by 1 on each out_valid && out_ready edge and wraps at 2^CNT_W-1 → 0.
- mode/sel are sampled only through the grant logic. A change takes effect on the next accept; a held word is never altered.
- Switching from fixed mode to RR mode: the search continues from the retained last.
- Reset asserted mid-stall: the held word is discarded, out_valid=0 immediately (async), no handshake is counted.
- Single-channel configurations are not supported (N_CH≥2).

Test Plan:
- Fixed mode, N_CH=16, W=16:
  - Channel c data=16'h3f00+c, all valid, out_ready=1, sel stepped 0,1,6,12.
  - Required: out_data=3f00,3f01,3f06,3f0c one cycle after each step, out_ch matches sel, in_ready one-hot at sel.
- RR fairness: mode=1, in_valid=16'h8421, out_ready=1 for 8 cycles.
  - Required: out_ch sequence 0,5,10,15,0,5,10,15.
  - xfer_cnt=8 after the last handshake.
- Backpressure: one word accepted, then out_ready=0 for 5 cycles while inputs change.
  - Required: out_data/out_ch frozen, in_ready=0 throughout, xfer_cnt unchanged.
  - Then out_ready=1 → handshake counted and the next granted word loads the same cycle.
- Boundary cases:
  - Fixed mode with sel=3 and in_valid[3]=0 (others 1) → no grant, out_valid falls to 0 after drain.
  - RR with only channel 15 valid, last=15 → wrap search grants 15 again.
- Counter wrap: CNT_W=4, 17 back-to-back transfers → xfer_cnt goes 15→0→1.
- Async reset during a stall (rst_n low mid-cycle) → out_valid=0, xfer_cnt=0 without waiting for clk.
  - After release the first RR grant goes to the lowest valid channel.
